mat_result_deskew: RTL and testbench

- Receiving end of the systolic matrix unit's result stream.
- Column j of a result row leaves the array j cycles after column 0. This block re-aligns the columns into whole row vectors.
- Aligned rows are buffered in a small row FIFO and handed to the downstream consumer over a valid/ready handshake.
- The array cannot be stalled, so FIFO overflow is reported rather than back-pressured.

---
 rtl/mat_pkg.sv | 9 +
 rtl/mat_row_fifo.sv | 64 ++++++
 rtl/mat_result_deskew.sv | 94 +++++++++
 tb/tb_mat_result_deskew.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared constants and row type for the matrix-unit result path.
package mat_pkg;

    localparam int unsigned MAT_WIDTH = 128;
    localparam int unsigned MAT_DEPTH = 4;

    typedef shortreal mat_row_t [MAT_WIDTH];

endpackage

// File: rtl/mat_row_fifo.sv
// Row FIFO holding whole aligned result rows; no fall-through, no bypass.
module mat_row_fifo
    import mat_pkg::*;
#(
    parameter int unsigned WIDTH = MAT_WIDTH,
    parameter int unsigned DEPTH = MAT_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  shortreal                 row_in  [WIDTH],
    output logic                     full,
    input  logic                     pop,
    output shortreal                 row_out [WIDTH],
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    shortreal        mem [DEPTH][WIDTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Status decode and accept logic; a pop frees the slot for a same-cycle push.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        for (int j = 0; j < int'(WIDTH); j++) begin
            row_out[j] = mem[rd_ptr][j];
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int d = 0; d < int'(DEPTH); d++) begin
                for (int j = 0; j < int'(WIDTH); j++) begin
                    mem[d][j] <= 0.0;
                end
            end
        end else begin
            if (do_push) begin
                for (int j = 0; j < int'(WIDTH); j++) begin
                    mem[wr_ptr][j] <= row_in[j];
                end
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mat_result_deskew.sv
// Re-aligns the skewed column outputs of the systolic array into whole rows
// and queues them for a valid/ready consumer. The array cannot stall, so a
// row arriving at a full FIFO is dropped and flagged in a sticky overflow.
module mat_result_deskew
    import mat_pkg::*;
#(
    parameter int unsigned WIDTH = MAT_WIDTH,
    parameter int unsigned DEPTH = MAT_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  shortreal                 sin     [WIDTH],
    output logic                     out_valid,
    input  logic                     out_ready,
    output shortreal                 out_row [WIDTH],
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    logic     av;
    logic     pop_req;
    logic     fifo_full;
    logic     fifo_empty;
    shortreal aligned [WIDTH];

    // Row-valid delay line: the last column leaves the array WIDTH-1 cycles after column 0.
    if (WIDTH == 1) begin : g_no_vdly
        assign av = in_valid;
    end else begin : g_vdly
        localparam int unsigned VW = WIDTH - 1;
        logic [VW-1:0] vdly;

        // Shift in_valid toward the aligned tap; reset drops rows in flight.
        always_ff @(posedge clock) begin
            if (reset) begin
                vdly <= '0;
            end else begin
                vdly <= (vdly << 1) | VW'(in_valid);
            end
        end

        assign av = vdly[VW-1];
    end

    // Per-column data delay: column j waits WIDTH-1-j cycles so all lanes meet.
    for (genvar j = 0; j < int'(WIDTH); j++) begin : g_lane
        localparam int unsigned STAGES = WIDTH - 1 - j;

        if (STAGES == 0) begin : g_pass
            assign aligned[j] = sin[j];
        end else begin : g_dly
            shortreal dly [STAGES];

            // Data-only shift register; validity is carried by the valid delay line.
            always_ff @(posedge clock) begin
                dly[0] <= sin[j];
                for (int k = 1; k < int'(STAGES); k++) begin
                    dly[k] <= dly[k-1];
                end
            end

            assign aligned[j] = dly[STAGES-1];
        end
    end

    assign pop_req   = out_valid && out_ready;
    assign out_valid = !fifo_empty;

    mat_row_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (av),
        .row_in  (aligned),
        .full    (fifo_full),
        .pop     (pop_req),
        .row_out (out_row),
        .empty   (fifo_empty),
        .count   (count)
    );

    // Sticky drop flag: an aligned row met a full FIFO with no pop to make room.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (av && fifo_full && !pop_req) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mat_result_deskew.sv
// Bench for mat_result_deskew: a WIDTH=4/DEPTH=2 instance checked every cycle
// against a queue-based row model, plus a WIDTH=1 instance driven from a table.
module tb_mat_result_deskew;

    localparam int unsigned W = 4;
    localparam int unsigned D = 2;
    localparam int          HMAX = 4096;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic     reset;
    logic     iv4, rdy4, ov4, ovf4;
    shortreal sin4 [W];
    shortreal row4 [W];
    logic [1:0] cnt4;
    logic     iv1, rdy1, ov1, ovf1;
    shortreal sin1 [1];
    shortreal row1 [1];
    logic [1:0] cnt1;

    mat_result_deskew #(.WIDTH(W), .DEPTH(D)) u_dut4 (
        .clock(clock), .reset(reset), .in_valid(iv4), .sin(sin4),
        .out_valid(ov4), .out_ready(rdy4), .out_row(row4),
        .count(cnt4), .overflow(ovf4)
    );

    mat_result_deskew #(.WIDTH(1), .DEPTH(D)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(iv1), .sin(sin1),
        .out_valid(ov1), .out_ready(rdy1), .out_row(row1),
        .count(cnt1), .overflow(ovf1)
    );

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;
    real hist [HMAX][W];   // lane values driven in each cycle
    int  rowid_at [HMAX];  // row id whose in_valid was in that cycle, else -1
    int  pend [$];         // start cycles of rows still travelling through the skew
    int  mq [$];           // start cycles of rows held in the FIFO, head first
    bit  ovf_m;

    typedef struct {
        bit  iv;
        real d;
        bit  rdy;
        bit  ev;
        real er;
        int  ec;
        bit  eo;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(bit iv, real d, bit rdy, bit ev, real er, int ec, bit eo);
        vec_t v;
        v.iv = iv; v.d = d; v.rdy = rdy; v.ev = ev; v.er = er; v.ec = ec; v.eo = eo;
        return v;
    endfunction

    function automatic real lane_val(int k, int j);
        return 1.0 + 10.0 * real'(k) + real'(j);
    endfunction

    task automatic chk(string nm, real act, real exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0g expected %0g", nm, cyc, act, exp);
        end
    endtask

    // Advance one clock; the model predicts the post-edge state from the rules.
    task automatic step();
        bit have_av;
        bit pop;
        bit full_before;
        int tav;
        have_av = 1'b0;
        tav = 0;
        if (cyc >= HMAX - 8) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HMAX - 8);
            n_bad++;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $fatal(1, "cycle budget exhausted");
        end
        for (int j = 0; j < int'(W); j++) hist[cyc][j] = real'(sin4[j]);
        if (iv4) pend.push_back(cyc);
        if (pend.size() > 0 && (cyc - pend[0]) == int'(W) - 1) begin
            have_av = 1'b1;
            tav = pend.pop_front();
        end
        pop = rdy4 && (mq.size() > 0);
        if (reset) begin
            pend.delete();
            mq.delete();
            ovf_m = 1'b0;
        end else begin
            full_before = (mq.size() == int'(D));
            if (pop) void'(mq.pop_front());
            if (have_av) begin
                if (!full_before || pop) mq.push_back(tav);
                else ovf_m = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        chk("out_valid", real'(ov4), (mq.size() > 0) ? 1.0 : 0.0);
        chk("count", real'(cnt4), real'(mq.size()));
        chk("overflow", real'(ovf4), real'(ovf_m));
        if (mq.size() > 0) begin
            for (int j = 0; j < int'(W); j++)
                chk($sformatf("out_row[%0d]", j), real'(row4[j]), hist[mq[0] + j][j]);
        end
    endtask

    // Drive one cycle of the WIDTH=4 instance; lane j carries row data j cycles late.
    task automatic drive(bit iv, bit rdy, int k);
        int s;
        iv4  = iv;
        rdy4 = rdy;
        rowid_at[cyc] = iv ? k : -1;
        for (int j = 0; j < int'(W); j++) begin
            s = cyc - j;
            if (s >= 0 && rowid_at[s] >= 0) sin4[j] = shortreal'(lane_val(rowid_at[s], j));
            else sin4[j] = shortreal'(-9.0 - real'($urandom_range(0, 7)));
        end
        step();
    endtask

    initial begin
        int t;
        int first;
        int mx;
        bit seen;

        for (int i = 0; i < HMAX; i++) rowid_at[i] = -1;
        ovf_m = 1'b0;
        iv4 = 1'b0; rdy4 = 1'b0; iv1 = 1'b0; rdy1 = 1'b0;
        sin1[0] = 0.0;
        for (int j = 0; j < int'(W); j++) sin4[j] = -9.0;

        // Reset state
        reset = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        for (int j = 0; j < int'(W); j++) chk($sformatf("rst_row4[%0d]", j), real'(row4[j]), 0.0);
        chk("rst_valid1", real'(ov1), 0.0);
        chk("rst_count1", real'(cnt1), 0.0);
        chk("rst_ovf1", real'(ovf1), 0.0);
        chk("rst_row1", real'(row1[0]), 0.0);
        reset = 1'b0;

        // 1: single row, latency WIDTH, then pop
        drive(0, 0, 0);
        t = cyc;
        drive(1, 0, 0);
        first = -1;
        for (int i = 0; i < 8 && first < 0; i++) begin
            drive(0, 0, 0);
            if (ov4) first = cyc;
        end
        chk("t1_latency", real'(first - t), 4.0);
        for (int j = 0; j < int'(W); j++) chk($sformatf("t1_row[%0d]", j), real'(row4[j]), 1.0 + real'(j));
        drive(0, 1, 0);
        chk("t1_popped_valid", real'(ov4), 0.0);
        chk("t1_popped_count", real'(cnt4), 0.0);

        // 2: streaming, one row per cycle
        mx = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, k + 1);
            if (int'(cnt4) > mx) mx = int'(cnt4);
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0);
            if (int'(cnt4) > mx) mx = int'(cnt4);
        end
        chk("t2_max_count", real'(mx), 1.0);
        chk("t2_overflow", real'(ovf4), 0.0);

        // 3: backpressure and overflow
        t = cyc;
        drive(1, 0, 20);
        drive(1, 0, 21);
        drive(1, 0, 22);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("t3_count_full", real'(cnt4), 2.0);
        chk("t3_ovf_before", real'(ovf4), 0.0);
        drive(0, 0, 0);
        chk("t3_cycle", real'(cyc - t), 6.0);
        chk("t3_ovf_after", real'(ovf4), 1.0);
        chk("t3_head_lane0", real'(row4[0]), lane_val(20, 0));
        for (int i = 0; i < 4; i++) drive(0, 1, 0);
        chk("t3_drained", real'(cnt4), 0.0);
        reset = 1'b1;
        drive(0, 0, 0);
        reset = 1'b0;
        chk("t3_ovf_cleared", real'(ovf4), 0.0);

        // 4: full FIFO with a pop in the cycle the third row aligns
        drive(1, 0, 30);
        drive(1, 0, 31);
        drive(1, 0, 32);
        drive(0, 0, 0);
        drive(0, 0, 0);
        drive(0, 1, 0);
        chk("t4_count", real'(cnt4), 2.0);
        chk("t4_overflow", real'(ovf4), 0.0);
        chk("t4_head_lane3", real'(row4[3]), lane_val(31, 3));
        for (int i = 0; i < 3; i++) drive(0, 1, 0);

        // 5: reset while a row is in flight
        t = cyc;
        drive(1, 0, 40);
        drive(0, 0, 0);
        reset = 1'b1;
        drive(0, 0, 0);
        reset = 1'b0;
        chk("t5_count", real'(cnt4), 0.0);
        chk("t5_overflow", real'(ovf4), 0.0);
        seen = 1'b0;
        while (cyc < t + 10) begin
            drive(0, 0, 0);
            if (ov4) seen = 1'b1;
        end
        chk("t5_no_ghost_row", real'(seen), 0.0);
        drive(1, 0, 41);
        first = -1;
        for (int i = 0; i < 8 && first < 0; i++) begin
            drive(0, 0, 0);
            if (ov4) first = cyc;
        end
        chk("t5_new_row_cycle", real'(first - t), 14.0);
        drive(0, 1, 0);

        // 6: WIDTH=1 instance from a table
        tbl.push_back(mk(1,  7.5,  0, 1,  7.5,  1, 0));
        tbl.push_back(mk(1,  2.5,  0, 1,  7.5,  2, 0));
        tbl.push_back(mk(1,  3.0,  1, 1,  2.5,  2, 0));
        tbl.push_back(mk(1,  4.0,  0, 1,  2.5,  2, 1));
        tbl.push_back(mk(0,  0.0,  1, 1,  3.0,  1, 1));
        tbl.push_back(mk(0,  0.0,  1, 0,  0.0,  0, 1));
        tbl.push_back(mk(0,  0.0,  1, 0,  0.0,  0, 1));
        tbl.push_back(mk(1, -1.25, 1, 1, -1.25, 1, 1));
        tbl.push_back(mk(0,  0.0,  1, 0,  0.0,  0, 1));
        for (int i = 0; i < tbl.size(); i++) begin
            iv1 = tbl[i].iv;
            sin1[0] = shortreal'(tbl[i].d);
            rdy1 = tbl[i].rdy;
            drive(0, 1, 0);
            chk($sformatf("w1_valid_%0d", i), real'(ov1), real'(tbl[i].ev));
            chk($sformatf("w1_count_%0d", i), real'(cnt1), real'(tbl[i].ec));
            chk($sformatf("w1_ovf_%0d", i), real'(ovf1), real'(tbl[i].eo));
            if (tbl[i].ev) chk($sformatf("w1_row_%0d", i), real'(row1[0]), tbl[i].er);
        end
        iv1 = 1'b0; rdy1 = 1'b0;
        reset = 1'b1;
        drive(0, 0, 0);
        reset = 1'b0;
        chk("w1_ovf_reset", real'(ovf1), 0.0);
        chk("w1_count_reset", real'(cnt1), 0.0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 50000)));
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) drive(0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
